systolic_skew_feeder: RTL

//  Input stage of the FFN systolic array, directly upstream of the mac grid.

---
 rtl/systolic_pkg.sv | 19 +
 rtl/skew_line.sv | 34 +++
 rtl/systolic_skew_feeder.sv | 98 +++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared defaults, feeder FSM encoding and lane packing helper for the FFN systolic array.
package systolic_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_N          = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } feeder_state_e;

  // Bit offset of lane 'lane' inside a packed vector of 'width'-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Enabled shift chain of DEPTH registers; DEPTH=0 degenerates to a wire.
module skew_line #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rstn, en};
      assign dout = din;
    end else begin : g_chain
      logic [DATA_WIDTH-1:0] stage_reg [DEPTH];

      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else if (en) begin
          stage_reg[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_skew_feeder.sv
// Input stage of the systolic array: skews lane i by i steps, drives acc_en and drains the wavefront.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    in_last_i,
  input  logic [N*DATA_WIDTH-1:0] a_data_i,
  input  logic [N*DATA_WIDTH-1:0] b_data_i,
  output logic [N*DATA_WIDTH-1:0] a_lane_o,
  output logic [N*DATA_WIDTH-1:0] b_lane_o,
  output logic                    acc_en_o,
  output logic                    busy_o,
  output logic                    tile_done_o
);

  localparam int              CNT_W      = $clog2(2 * N);
  // Unreachable when N=1 (no DRAIN state), so the wrapped value is harmless there.
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2 * (N - 1) - 1);

  feeder_state_e    state_reg, state_next;
  logic [CNT_W-1:0] drain_cnt_reg, drain_cnt_next;
  logic             accept;
  logic             draining;
  logic             step;

  assign in_ready_o  = (state_reg == IDLE) || (state_reg == STREAM);
  assign draining    = (state_reg == DRAIN);
  assign accept      = in_ready_o && in_valid_i;
  assign step        = accept || draining;
  assign acc_en_o    = step;
  assign busy_o      = (state_reg != IDLE);
  assign tile_done_o = (state_reg == DONE);

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = '0;
    unique case (state_reg)
      IDLE, STREAM: begin
        if (accept) begin
          if (!in_last_i)  state_next = STREAM;
          else if (N == 1) state_next = DONE;
          else             state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt_reg == DRAIN_LAST) state_next = DONE;
        else drain_cnt_next = drain_cnt_reg + CNT_W'(1);
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  // While draining, zeros are pushed in behind the last real beat to flush the wavefront.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] a_in;
      logic [DATA_WIDTH-1:0] b_in;

      assign a_in = draining ? '0 : a_data_i[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH];
      assign b_in = draining ? '0 : b_data_i[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH];

      skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(gi)) u_skew_a (
        .clk  (clk),
        .rstn (rstn),
        .en   (step),
        .din  (a_in),
        .dout (a_lane_o[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH])
      );

      skew_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(gi)) u_skew_b (
        .clk  (clk),
        .rstn (rstn),
        .en   (step),
        .din  (b_in),
        .dout (b_lane_o[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH])
      );
    end
  endgenerate

endmodule
